// File: rtl/alarme_pkg.sv
// Shared definitions for the seat-belt warning sequencer: state codes,
// default timing constants and the counter width helper.
package alarme_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      ALERTA   = 2'd2,
      AVISO    = 2'd3
   } estado_t;

   localparam int DEF_TICK_DIV    = 1000;
   localparam int DEF_DEB_TICKS   = 4;
   localparam int DEF_BLINK_TICKS = 5;
   localparam int DEF_BUZZ_TICKS  = 60;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alarme_tick_gen.sv
// Free-running prescaler: one-clock tick every TICK_DIV clocks, the first
// one TICK_DIV clocks after reset release.
module alarme_tick_gen
   import alarme_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/alarme_sequenciador.sv
// Seat-belt warning sequencer: debounces the detector request, then blinks
// lamp and buzzer for a bounded time and finally holds a steady lamp.
module alarme_sequenciador
   import alarme_pkg::*;
#(
   parameter int TICK_DIV    = DEF_TICK_DIV,
   parameter int DEB_TICKS   = DEF_DEB_TICKS,
   parameter int BLINK_TICKS = DEF_BLINK_TICKS,
   parameter int BUZZ_TICKS  = DEF_BUZZ_TICKS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       luz_req,
   input  logic       ignicao,
   input  logic       ack,
   output logic       luz_out,
   output logic       buzzer,
   output logic [1:0] estado
);

   localparam int DEB_W   = cnt_width(DEB_TICKS);
   localparam int BLINK_W = cnt_width(BLINK_TICKS);
   localparam int BUZZ_W  = cnt_width(BUZZ_TICKS);

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_TICKS - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
   localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_TICKS - 1);

   logic tick;

   estado_t            st, st_nx;
   logic [DEB_W-1:0]   deb_cnt, deb_nx;
   logic [BLINK_W-1:0] blink_cnt, blink_nx;
   logic [BUZZ_W-1:0]  buzz_cnt, buzz_nx;
   logic               luz_q, luz_nx;
   logic               buz_q, buz_nx;

   alarme_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         deb_cnt   <= '0;
         blink_cnt <= '0;
         buzz_cnt  <= '0;
         luz_q     <= 1'b0;
         buz_q     <= 1'b0;
      end else begin
         st        <= st_nx;
         deb_cnt   <= deb_nx;
         blink_cnt <= blink_nx;
         buzz_cnt  <= buzz_nx;
         luz_q     <= luz_nx;
         buz_q     <= buz_nx;
      end
   end

   // Outputs are computed for the next state so they change on the same
   // edge as the transition.
   always_comb begin
      st_nx    = st;
      deb_nx   = deb_cnt;
      blink_nx = blink_cnt;
      buzz_nx  = buzz_cnt;
      luz_nx   = luz_q;
      buz_nx   = buz_q;

      if (!ignicao || !luz_req) begin
         st_nx    = IDLE;
         deb_nx   = '0;
         blink_nx = '0;
         buzz_nx  = '0;
         luz_nx   = 1'b0;
         buz_nx   = 1'b0;
      end else begin
         unique case (st)
            IDLE: begin
               st_nx  = DEBOUNCE;
               deb_nx = '0;
               luz_nx = 1'b0;
               buz_nx = 1'b0;
            end
            DEBOUNCE: begin
               luz_nx = 1'b0;
               buz_nx = 1'b0;
               if (tick) begin
                  if (deb_cnt == DEB_LAST) begin
                     st_nx    = ALERTA;
                     luz_nx   = 1'b1;
                     buz_nx   = 1'b1;
                     blink_nx = '0;
                     buzz_nx  = '0;
                  end else begin
                     deb_nx = deb_cnt + DEB_W'(1);
                  end
               end
            end
            ALERTA: begin
               // ack and the final buzz tick share one exit path.
               if (ack || (tick && (buzz_cnt == BUZZ_LAST))) begin
                  st_nx  = AVISO;
                  luz_nx = 1'b1;
                  buz_nx = 1'b0;
               end else if (tick) begin
                  buzz_nx = buzz_cnt + BUZZ_W'(1);
                  if (blink_cnt == BLINK_LAST) begin
                     blink_nx = '0;
                     luz_nx   = ~luz_q;
                     buz_nx   = ~luz_q;
                  end else begin
                     blink_nx = blink_cnt + BLINK_W'(1);
                  end
               end
            end
            AVISO: begin
               luz_nx = 1'b1;
               buz_nx = 1'b0;
            end
            default: begin
               st_nx  = IDLE;
               luz_nx = 1'b0;
               buz_nx = 1'b0;
            end
         endcase
      end
   end

   assign luz_out = luz_q;
   assign buzzer  = buz_q;
   assign estado  = st;

endmodule

// File: tb/tb_alarme_sequenciador.sv
// Directed bench for alarme_sequenciador with TICK_DIV=4, DEB_TICKS=2,
// BLINK_TICKS=2, BUZZ_TICKS=8; edge numbers count clocks after reset release.
`timescale 1ns/1ps
module tb_alarme_sequenciador;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       luz_req;
   logic       ignicao;
   logic       ack;
   logic       luz_out;
   logic       buzzer;
   logic [1:0] estado;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alarme_sequenciador #(
      .TICK_DIV   (4),
      .DEB_TICKS  (2),
      .BLINK_TICKS(2),
      .BUZZ_TICKS (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .luz_req(luz_req),
      .ignicao(ignicao),
      .ack    (ack),
      .luz_out(luz_out),
      .buzzer (buzzer),
      .estado (estado)
   );

   task automatic confere(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Advance n clock edges, checking all outputs 1ns after each edge.
   task automatic ciclos(input int n, input logic [1:0] e, input logic l, input logic b,
                         input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         confere({tag, ".estado"}, 8'(estado), 8'(e));
         confere({tag, ".luz"}, 8'(luz_out), 8'(l));
         confere({tag, ".buzzer"}, 8'(buzzer), 8'(b));
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      luz_req = 1'b1;
      ignicao = 1'b1;
      ack     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      confere("rst.estado", 8'(estado), 8'd0);
      confere("rst.luz", 8'(luz_out), 8'd0);
      confere("rst.buzzer", 8'(buzzer), 8'd0);
      rst_n = 1'b1;

      // Nominal: debounce 1..7, ALERTA at 8, toggles every 8, AVISO at 40
      ciclos(1, 2'd1, 1'b0, 1'b0, "nom.deb_in");
      ciclos(6, 2'd1, 1'b0, 1'b0, "nom.deb");
      ciclos(8, 2'd2, 1'b1, 1'b1, "nom.on1");
      ciclos(8, 2'd2, 1'b0, 1'b0, "nom.off1");
      ciclos(8, 2'd2, 1'b1, 1'b1, "nom.on2");
      ciclos(8, 2'd2, 1'b0, 1'b0, "nom.off2");
      ciclos(1, 2'd3, 1'b1, 1'b0, "nom.aviso");

      // ack ignored in AVISO, then ignition drop and restart (ALERTA at 48)
      ack = 1'b1;
      ciclos(1, 2'd3, 1'b1, 1'b0, "ign.ack_aviso");
      ack = 1'b0;
      ignicao = 1'b0;
      ciclos(1, 2'd0, 1'b0, 1'b0, "ign.drop");
      ignicao = 1'b1;
      ciclos(5, 2'd1, 1'b0, 1'b0, "ign.deb");
      ciclos(1, 2'd2, 1'b1, 1'b1, "ign.alerta");

      // Early ack sampled at edge 58, ten clocks into ALERTA
      ciclos(7, 2'd2, 1'b1, 1'b1, "ack.on");
      ciclos(2, 2'd2, 1'b0, 1'b0, "ack.off");
      ack = 1'b1;
      ciclos(1, 2'd3, 1'b1, 1'b0, "ack.early");
      ack = 1'b0;
      ciclos(2, 2'd3, 1'b1, 1'b0, "ack.hold");
      ack = 1'b1;
      ciclos(1, 2'd3, 1'b1, 1'b0, "ack.late");
      ack = 1'b0;

      // Belt buckled during the lamp-off phase, then full restart
      luz_req = 1'b0;
      ciclos(1, 2'd0, 1'b0, 1'b0, "belt.idle0");
      luz_req = 1'b1;
      ciclos(5, 2'd1, 1'b0, 1'b0, "belt.deb0");
      ciclos(8, 2'd2, 1'b1, 1'b1, "belt.on0");
      ciclos(2, 2'd2, 1'b0, 1'b0, "belt.off0");
      luz_req = 1'b0;
      ciclos(1, 2'd0, 1'b0, 1'b0, "belt.buckle");
      luz_req = 1'b1;
      ciclos(5, 2'd1, 1'b0, 1'b0, "belt.deb1");
      ciclos(8, 2'd2, 1'b1, 1'b1, "belt.on1");
      ciclos(8, 2'd2, 1'b0, 1'b0, "belt.off1");
      ciclos(8, 2'd2, 1'b1, 1'b1, "belt.on2");
      ciclos(8, 2'd2, 1'b0, 1'b0, "belt.off2");
      ciclos(1, 2'd3, 1'b1, 1'b0, "belt.aviso");

      // Glitch: request high for 5 clocks spanning one tick
      luz_req = 1'b0;
      ciclos(1, 2'd0, 1'b0, 1'b0, "gl.idle");
      luz_req = 1'b1;
      ciclos(5, 2'd1, 1'b0, 1'b0, "gl.deb");
      luz_req = 1'b0;
      ciclos(1, 2'd0, 1'b0, 1'b0, "gl.back");

      // Asynchronous reset in the middle of ALERTA (entered at edge 132)
      luz_req = 1'b1;
      ciclos(8, 2'd1, 1'b0, 1'b0, "ar.deb");
      ciclos(2, 2'd2, 1'b1, 1'b1, "ar.alerta");
      #2;
      rst_n = 1'b0;
      #1;
      confere("ar.estado", 8'(estado), 8'd0);
      confere("ar.luz", 8'(luz_out), 8'd0);
      confere("ar.buzzer", 8'(buzzer), 8'd0);
      ciclos(2, 2'd0, 1'b0, 1'b0, "ar.held");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarme_sequenciador.md
Name: alarme_sequenciador

Overview:
Timed seat-belt warning sequencer. It sits directly downstream of the combinational seat-belt alarm detector and consumes its raw light request (driver seated, belt open, ignition on). It debounces that request, then drives a blinking lamp and a beeping buzzer for a bounded time. After that it holds a steady lamp until the request clears.

Parameters:
TICK_DIV, 1000, clocks per timebase tick (>=2)
DEB_TICKS, 4, ticks the request must stay high before alerting (>=1)
BLINK_TICKS, 5, ticks per lamp half-period in ALERTA (>=1)
BUZZ_TICKS, 60, ticks spent in ALERTA before falling back to AVISO (>=1)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  asynchronous active-low reset
luz_req  in  1  raw request from the seat-belt detector, synchronous to clk
ignicao  in  1  ignition status
ack  in  1  one-cycle driver acknowledge; silences the buzzer early
luz_out  out  1  warning lamp drive
buzzer  out  1  buzzer drive
estado  out  2  current state code, for debug

Behaviour:
- Reset: rst_n low clears everything asynchronously: luz_out=0, buzzer=0, estado=IDLE, all counters=0. Reset applies mid-sequence and loses all progress. Release is synchronous-safe: the first state change can happen at the first clk edge after rst_n rises.
- Timebase: free-running counter 0..TICK_DIV-1. An internal tick pulses for one clock when count==TICK_DIV-1, then the counter wraps to 0. First tick comes TICK_DIV clocks after reset release.
- State codes: IDLE=0, DEBOUNCE=1, ALERTA=2, AVISO=3.
- Outputs are registered. They take the value of the new state at the same edge as the state transition.
- Global priority:
  - ignicao=0 forces IDLE at the next edge from any state, with luz_out=0 and buzzer=0.
  - Otherwise luz_req=0 forces IDLE at the next edge from any state.
- IDLE:
  - outputs 0
  - luz_req=1 and ignicao=1 -> DEBOUNCE; deb_cnt=0
- DEBOUNCE:
  - outputs 0
  - deb_cnt increments on each tick
  - on the tick where deb_cnt==DEB_TICKS-1 -> ALERTA, with luz_out=1, buzzer=1, blink_cnt=0, buzz_cnt=0
- ALERTA:
  - blink_cnt increments on tick. On the tick where blink_cnt==BLINK_TICKS-1, toggle luz_out and clear blink_cnt.
  - buzzer always equals luz_out, so the beep is in phase with the lamp.
  - buzz_cnt increments on tick. On the tick where buzz_cnt==BUZZ_TICKS-1 -> AVISO.
  - ack=1 -> AVISO at the next edge.
  - If ack and the final tick coincide, the result is the same: AVISO.
- AVISO:
  - luz_out=1 steady, buzzer=0
  - stays until luz_req or ignicao drops
  - ack ignored
- ack in IDLE, DEBOUNCE or AVISO: no effect.
- Re-arm: a new request after IDLE restarts the full DEBOUNCE/ALERTA sequence. There is no memory of a previous silence.
- Counter widths: $clog2 of the corresponding parameter, minimum 1 bit. Counters never exceed parameter-1, so no overflow is possible.
- A luz_req glitch shorter than DEB_TICKS ticks never produces any output activity.

Decomposition:
- Shared package alarme_pkg holds:
  - 2-bit state constants IDLE/DEBOUNCE/ALERTA/AVISO
  - default parameter constants, reused by the detector bench
- One natural sub-module: alarme_tick_gen.
  - Parameter: TICK_DIV. Ports: clk, rst_n, tick.
  - It is the free-running prescaler described above.
- FSM, counters and output registers live in alarme_sequenciador.

Test Plan:
(Benches use TICK_DIV=4, DEB_TICKS=2, BLINK_TICKS=2, BUZZ_TICKS=8.)
1. Reset: assert rst_n=0 mid-ALERTA with luz_out=1 -> luz_out=0, buzzer=0, estado=0 immediately, without waiting for a clk edge.
2. Nominal: ignicao=1, luz_req=1 held from reset release -> estado=1 after 1 clock; estado=2 with luz_out=buzzer=1 at the edge of the 2nd tick (clock 8); luz_out/buzzer toggle every 8 clocks; estado=3 with luz_out=1, buzzer=0 exactly 32 clocks after entering ALERTA.
3. Glitch: luz_req high for 5 clocks (one tick), then low -> estado goes 1 then 0; luz_out and buzzer stay 0 throughout.
4. Early ack: one-cycle ack pulse 10 clocks into ALERTA -> estado=3, buzzer=0, luz_out=1 at the next edge; a later ack has no effect.
5. Ignition drop: ignicao=0 while luz_req=1 in AVISO -> estado=0, luz_out=0 at the next edge. Ignition back with luz_req=1 -> full debounce sequence restarts.
6. Belt buckled: luz_req falls mid-ALERTA while luz_out=0 phase -> IDLE at the next edge. Re-raising luz_req restarts from DEBOUNCE with blink and buzz counters cleared.
